// File: rtl/top_cnt.sv
// Prescaled 6-bit wrap counter: cnt6 advances once every num clk cycles and wraps after MAX_CNT.
// Optional one-cycle wrap pulse on 'carry' when CNT_CARRY_EN is defined; latency num edges per step.

module cnt6 #(
    parameter int MAX_CNT = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [5:0] out
);
    localparam logic [5:0] MAX_V = 6'(MAX_CNT);

    logic [5:0] cnt_q, cnt_d;

    // Any value at or above the terminal count reloads zero, so a corrupted state self-heals.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q >= MAX_V) ? 6'd0 : cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 6'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out = cnt_q;
endmodule

module top_cnt #(
    parameter int MAX_CNT = 59
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] num,
    output logic [5:0]  out
`ifdef CNT_CARRY_EN
    ,
    output logic        carry
`endif
);
    logic [31:0] pcnt_q, pcnt_d;
    logic        tick;

    // The >= compare lets a shrinking num end the running period at once.
    assign tick   = (num <= 32'd1) || (pcnt_q >= num - 32'd1);
    assign pcnt_d = tick ? 32'd0 : pcnt_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= 32'd0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    cnt6 #(
        .MAX_CNT (MAX_CNT)
    ) u_cnt6 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick),
        .out   (out)
    );

`ifdef CNT_CARRY_EN
    logic carry_q, carry_d;

    assign carry_d = tick && (out == 6'(MAX_CNT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry = carry_q;
`endif
endmodule

// File: tb/tb_top_cnt.sv
// Directed bench for top_cnt: prescaler timing, wrap, async reset, num change and optional carry.
module tb_top_cnt;
    logic        clk;
    logic        rst_n;
    logic [31:0] num;
    logic [5:0]  out;
`ifdef CNT_CARRY_EN
    logic        carry;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    top_cnt #(
        .MAX_CNT (59)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .num   (num),
        .out   (out)
`ifdef CNT_CARRY_EN
        ,
        .carry (carry)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset for one cycle, releasing on a falling edge so the next posedge is edge 1.
    task automatic do_reset(input logic [31:0] n);
        @(negedge clk);
        rst_n = 1'b0;
        num   = n;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        num   = 32'd4;
        #2;
        check("reset_out", 32'(out), 32'd0);

        // Period 4: out becomes e/4 after edge e.
        do_reset(32'd4);
        for (int e = 1; e <= 8; e++) begin
            step(1);
            check($sformatf("num4_edge%0d", e), 32'(out), 32'(e / 4));
        end

        // Period 1: wrap after 60 edges.
        do_reset(32'd1);
        step(59);
        check("num1_edge59", 32'(out), 32'd59);
        step(1);
        check("num1_edge60_wrap", 32'(out), 32'd0);
        step(1);
        check("num1_edge61", 32'(out), 32'd1);

        // Async reset mid-period at out=5, then restart timing.
        do_reset(32'd4);
        step(20);
        check("arst_pre_out5", 32'(out), 32'd5);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_immediate", 32'(out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        check("arst_edge3_hold", 32'(out), 32'd0);
        step(1);
        check("arst_edge4_inc", 32'(out), 32'd1);

        // num 10 -> 5 with pcnt=7: tick right away, then 5-cycle periods.
        do_reset(32'd10);
        step(7);
        check("shrink_pre", 32'(out), 32'd0);
        @(negedge clk);
        num = 32'd5;
        step(1);
        check("shrink_tick", 32'(out), 32'd1);
        step(4);
        check("shrink_hold", 32'(out), 32'd1);
        step(1);
        check("shrink_period5", 32'(out), 32'd2);

        // num 0: every edge increments.
        do_reset(32'd0);
        for (int e = 1; e <= 3; e++) begin
            step(1);
            check($sformatf("num0_edge%0d", e), 32'(out), 32'(e));
        end
        step(60);
        check("num0_edge63", 32'(out), 32'd3);

`ifdef CNT_CARRY_EN
        do_reset(32'd2);
        step(119);
        check("carry_edge119", 32'(carry), 32'd0);
        check("out_edge119", 32'(out), 32'd59);
        step(1);
        check("carry_edge120", 32'(carry), 32'd1);
        check("out_edge120", 32'(out), 32'd0);
        step(1);
        check("carry_edge121", 32'(carry), 32'd0);
        step(119);
        check("carry_edge240", 32'(carry), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/top_cnt.md
TOP_CNT -- requirements
Module: top_cnt

Interface
REQ-001 The block SHALL have parameter MAX_CNT, default 59, meaning the terminal value of the 6-bit counter (legal range 1..63).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock, all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port num, input, 32 bits: prescaler period in clk cycles (50000000 gives a 1 s tick at 50 MHz).
REQ-005 The block SHALL have port out, output, 6 bits: current count value, driven directly from a register.
REQ-006 The block SHALL have port carry, output, 1 bit, present only when CNT_CARRY_EN is defined: one-cycle wrap pulse.

Function
REQ-007 The block SHALL contain a 32-bit prescaler register pcnt that increments by 1 each clk edge.
REQ-008 The block SHALL assert the internal signal tick combinationally when (num <= 1) or (pcnt >= num-1).
- pcnt SHALL clear to 0 on the same edge.
- The >= compare makes a mid-run decrease of num end the current period immediately.
REQ-009 With num = 0 or num = 1, tick SHALL be high every cycle, so out increments every clk.
REQ-010 The block SHALL contain a submodule cnt6 with ports out[5:0], clk, rst_n and an enable input tied to tick.
REQ-011 cnt6 SHALL increment out by 1 on each clk edge with enable high.
- MAX_CNT+1 wraps to 0, so with the default out runs 0,1,...,59,0.
- With enable low, out SHALL hold.
REQ-012 cnt6 with enable tied high (standalone use) SHALL count every clk: 0..59 in 60 cycles, then wrap.
REQ-013 Latency: after reset release, out SHALL first change to 1 on the num-th rising clk edge (num >= 2).
- Every later change SHALL follow exactly num edges after the previous one.
REQ-014 If out ever holds a value above MAX_CNT, the next enabled edge SHALL load 0.
REQ-015 All arithmetic SHALL be unsigned.
- pcnt SHALL never exceed num-1 at steady state, so no 32-bit overflow occurs.

Reset
REQ-016 rst_n low SHALL immediately, without waiting for a clk edge, force pcnt = 0, out = 6'd0 and carry = 0.
REQ-017 Reset asserted mid-count SHALL discard the partial prescaler period.
- After release, timing SHALL restart per REQ-013.
REQ-018 No other reset source SHALL exist.
- Release SHALL be taken on the first rising clk edge with rst_n high.

Configuration
REQ-019 Macro CNT_CARRY_EN defined: output carry SHALL be a registered pulse, high for exactly one clk cycle.
- That cycle SHALL be the one in which out transitions MAX_CNT -> 0.
REQ-020 Macro CNT_CARRY_EN undefined: port carry and its logic SHALL be absent.
- All other behaviour SHALL be identical.

Verification
REQ-021 num=4, rst_n low for 1 cycle then high -> out=1 after edge 4, out=2 after edge 8, steady 4-cycle period.
REQ-022 num=1, run 61 cycles -> out counts 0..59, then 0, then 1 (wrap every 60 cycles).
REQ-023 CNT_CARRY_EN defined, num=2 -> carry high for one cycle, concurrent with out 59->0, every 120 cycles.
REQ-024 num=4, assert rst_n low asynchronously mid-period with out=5 -> out=0 immediately, next increment 4 edges after release.
REQ-025 num=10, pcnt=7, then num changed to 5 -> tick on the next edge, then periods of 5 cycles.
REQ-026 num=0 -> out increments every clk, with no lockup.
